// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_LOCK_EN adds req0_lock/req1_lock to hold the grant across chained ops.
module alu_arbiter #(
    parameter int WORDSIZE = 16,
    parameter int FLAGW    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [3:0]          req0_op,
    input  logic [WORDSIZE-1:0] req0_a,
    input  logic [WORDSIZE-1:0] req0_b,
`ifdef ALU_ARB_LOCK_EN
    input  logic                req0_lock,
    input  logic                req1_lock,
`endif
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [3:0]          req1_op,
    input  logic [WORDSIZE-1:0] req1_a,
    input  logic [WORDSIZE-1:0] req1_b,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [WORDSIZE-1:0] rsp0_result,
    output logic [FLAGW-1:0]    rsp0_flags,
    output logic                rsp0_err,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [WORDSIZE-1:0] rsp1_result,
    output logic [FLAGW-1:0]    rsp1_flags,
    output logic                rsp1_err,
    output logic [3:0]          alu_op,
    output logic [WORDSIZE-1:0] alu_a,
    output logic [WORDSIZE-1:0] alu_b,
    input  logic [WORDSIZE-1:0] alu_result,
    input  logic [FLAGW-1:0]    alu_flags,
    output logic                busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic                  r_gnt;
    logic [3:0]            r_op;
    logic [WORDSIZE-1:0]   r_a;
    logic [WORDSIZE-1:0]   r_b;
    logic [WORDSIZE-1:0]   r_result;
    logic [FLAGW-1:0]      r_flags;
    logic                  r_err;

    logic w_any;
    logic w_sel;
    logic w_take;
    logic w_rsv;
    logic w_rsp_hs;
    logic w_lock_hold;

`ifdef ALU_ARB_LOCK_EN
    logic r_locked;
    logic r_lock_pend;
    // The lock owner is always the last granted requester.
    assign w_lock_hold = r_locked & (r_last ? req1_valid : req0_valid);
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_any    = req0_valid | req1_valid;
    assign w_sel    = w_lock_hold ? r_last
                    : (req0_valid & req1_valid) ? ~r_last
                    : req1_valid;
    assign w_rsv    = (r_op >= 4'hD);
    assign w_rsp_hs = r_gnt ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_next      = r_state;
        w_take      = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp0_result = '0;
        rsp0_flags  = '0;
        rsp0_err    = 1'b0;
        rsp1_valid  = 1'b0;
        rsp1_result = '0;
        rsp1_flags  = '0;
        rsp1_err    = 1'b0;
        alu_op      = 4'h0;
        alu_a       = '0;
        alu_b       = '0;
        busy        = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_IDLE: begin
                    req0_ready = w_any & ~w_sel;
                    req1_ready = w_any & w_sel;
                    w_take     = w_any;
                    if (w_any) w_next = S_EXEC;
                end
                S_EXEC: begin
                    busy = 1'b1;
                    if (!w_rsv) begin
                        alu_op = r_op;
                        alu_a  = r_a;
                        alu_b  = r_b;
                    end
                    w_next = S_RESP;
                end
                S_RESP: begin
                    busy = 1'b1;
                    if (r_gnt) begin
                        rsp1_valid  = 1'b1;
                        rsp1_result = r_result;
                        rsp1_flags  = r_flags;
                        rsp1_err    = r_err;
                    end else begin
                        rsp0_valid  = 1'b1;
                        rsp0_result = r_result;
                        rsp0_flags  = r_flags;
                        rsp0_err    = r_err;
                    end
                    if (w_rsp_hs) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_op     <= 4'h0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_err    <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            r_locked    <= 1'b0;
            r_lock_pend <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_gnt <= w_sel;
                r_op  <= w_sel ? req1_op : req0_op;
                r_a   <= w_sel ? req1_a : req0_a;
                r_b   <= w_sel ? req1_b : req0_b;
`ifdef ALU_ARB_LOCK_EN
                r_lock_pend <= w_sel ? req1_lock : req0_lock;
`endif
            end
            if (r_state == S_EXEC) begin
                r_result <= w_rsv ? '0 : alu_result;
                r_flags  <= w_rsv ? '0 : alu_flags;
                r_err    <= w_rsv;
            end
            if (r_state == S_RESP && w_rsp_hs) begin
                r_last <= r_gnt;
`ifdef ALU_ARB_LOCK_EN
                r_locked <= r_lock_pend;
`endif
            end
`ifdef ALU_ARB_LOCK_EN
            // Owner went idle: release so round-robin resumes.
            if (r_state == S_IDLE && r_locked && !w_lock_hold)
                r_locked <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the two-requester ALU arbiter.
module tb_alu_arbiter;

    localparam int W  = 16;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]    req0_op, req1_op;
    logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
`ifdef ALU_ARB_LOCK_EN
    logic          req0_lock, req1_lock;
`endif
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0]  rsp0_result, rsp1_result;
    logic [FW-1:0] rsp0_flags, rsp1_flags;
    logic          rsp0_err, rsp1_err;
    logic [3:0]    alu_op;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [FW-1:0] alu_flags;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in combinational ALU: {flags, result}.
    function automatic logic [FW+W-1:0] ref_alu(input logic [3:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] r;
        case (op)
            4'h0:    s = {1'b0, a} + {1'b0, b};
            4'h1:    s = {1'b0, a} + {1'b0, b} + 17'd1;
            4'h2:    s = {1'b0, a} - {1'b0, b};
            default: s = {1'b0, a ^ {b[7:0], b[15:8]}};
        endcase
        r = s[W-1:0];
        return {op, 2'b00, s[W], (r == '0), r};
    endfunction

    always_comb {alu_flags, alu_result} = ref_alu(alu_op, alu_a, alu_b);

    alu_arbiter #(.WORDSIZE(W), .FLAGW(FW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
`ifdef ALU_ARB_LOCK_EN
        .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
`ifdef ALU_ARB_LOCK_EN
        req0_lock = 0; req1_lock = 0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 16'h00AA; req1_a = 16'h0055;
        cyc();
        cyc();
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got rdy=%b%b vld=%b%b busy=%b, expected all 0",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy);
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h, expected 0", alu_op, alu_a, alu_b);
        end
        checks++;
        if ({rsp0_result, rsp1_result, rsp0_flags, rsp1_flags, rsp0_err, rsp1_err} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got r0=%h r1=%h, expected 0", rsp0_result, rsp1_result);
        end
        rst = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_tie: got rdy0=%b rdy1=%b, expected 1 0", req0_ready, req1_ready);
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_op = 4'h0; req0_a = 16'h0005; req0_b = 16'h0003;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got rdy=%b busy=%b, expected 1 0", req0_ready, busy);
        end
        cyc();
        req0_valid = 0;
        #1;
        checks++;
        if (busy !== 1'b1 || {alu_op, alu_a, alu_b} !== {4'h0, 16'h0005, 16'h0003}) begin
            errors++;
            $display("FAIL single_exec: got busy=%b op=%h a=%h b=%h, expected 1 0 0005 0003",
                     busy, alu_op, alu_a, alu_b);
        end
        checks++;
        if (rsp0_valid !== 1'b0 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got vld=%b rdy=%b, expected 0 0", rsp0_valid, req0_ready);
        end
        cyc();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 16'h0008 || rsp0_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp: got vld=%b res=%h err=%b busy=%b, expected 1 0008 0 1",
                     rsp0_valid, rsp0_result, rsp0_err, busy);
        end
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0) begin
            errors++;
            $display("FAIL single_resp_alu: got op=%h a=%h b=%h, expected 0", alu_op, alu_a, alu_b);
        end
        rsp0_ready = 1;
        cyc();
        rsp0_ready = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got busy=%b vld=%b, expected 0 0", busy, rsp0_valid);
        end
    endtask

    task automatic test_tie();
        int exp_g[4] = '{0, 1, 0, 1};
        int n = 0;
        int c = 0;
        int last_c = 0;
        do_reset();
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 16'h0011; req1_a = 16'h0022; req0_b = 16'h0001; req1_b = 16'h0002;
        #1;
        while (n < 4 && c < 30) begin
            if (req0_ready || req1_ready) begin
                checks++;
                if ((req1_ready ? 1 : 0) != exp_g[n] || (req0_ready && req1_ready)) begin
                    errors++;
                    $display("FAIL tie_grant%0d: got rdy0=%b rdy1=%b, expected requester %0d",
                             n, req0_ready, req1_ready, exp_g[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last_c != 3) begin
                        errors++;
                        $display("FAIL tie_spacing%0d: got %0d cycles, expected 3", n, c - last_c);
                    end
                end
                last_c = c;
                n++;
            end
            cyc();
            c++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL tie_count: got %0d accepts, expected 4", n);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_valid = 1; req1_op = 4'h0; req1_a = 16'h1234; req1_b = 16'h0101;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: got rdy1=%b, expected 1", req1_ready);
        end
        cyc();
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'h0; req0_a = 16'h0001; req0_b = 16'h0002;
        cyc();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp1_valid !== 1'b1 || rsp1_result !== 16'h1335 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b res=%h rdy0=%b, expected 1 1335 0",
                         i, rsp1_valid, rsp1_result, req0_ready);
            end
            cyc();
        end
        rsp1_ready = 1;
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_handshake: got vld=%b rdy0=%b, expected 1 0", rsp1_valid, req0_ready);
        end
        cyc();
        rsp1_ready = 0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume: got rdy0=%b vld1=%b, expected 1 0", req0_ready, rsp1_valid);
        end
    endtask

    task automatic test_reserved();
        do_reset();
        req1_valid = 1; req1_op = 4'hE;
        req1_a = 16'($urandom) | 16'h0001; req1_b = 16'($urandom) | 16'h0100;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsv_accept: got rdy1=%b, expected 1", req1_ready);
        end
        cyc();
        req1_valid = 0;
        #1;
        checks++;
        if ({alu_op, alu_a, alu_b} !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rsv_exec: got op=%h a=%h b=%h busy=%b, expected 0 0 0 1",
                     alu_op, alu_a, alu_b, busy);
        end
        cyc();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_result !== 16'h0000 ||
            rsp1_flags !== 8'h00 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsv_rsp: got vld=%b err=%b res=%h flg=%h vld0=%b, expected 1 1 0000 00 0",
                     rsp1_valid, rsp1_err, rsp1_result, rsp1_flags, rsp0_valid);
        end
        rsp1_ready = 1;
        cyc();
        rsp1_ready = 0;
    endtask

    task automatic test_rst_exec();
        do_reset();
        req0_valid = 1; req0_a = 16'h0101; req0_b = 16'h0202;
        cyc();
        req0_valid = 0;
        cyc();
        rsp0_ready = 1;
        cyc();
        rsp0_ready = 0;
        req1_valid = 1; req1_op = 4'h0; req1_a = 16'h4321; req1_b = 16'h0007;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: got rdy1=%b, expected 1", req1_ready);
        end
        cyc();
        req1_valid = 0;
        rsp1_ready = 1;
        rst = 1;
        #1;
        checks++;
        if ({busy, alu_op, alu_a, alu_b, rsp1_valid} !== '0) begin
            errors++;
            $display("FAIL rst_during: got busy=%b op=%h a=%h b=%h, expected 0",
                     busy, alu_op, alu_a, alu_b);
        end
        cyc();
        rst = 0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: got busy=%b vld1=%b, expected 0 0", busy, rsp1_valid);
        end
        cyc();
        checks++;
        if (rsp1_valid !== 1'b0 || rsp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rsp: got vld0=%b vld1=%b, expected 0 0", rsp0_valid, rsp1_valid);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_tie: got rdy0=%b rdy1=%b, expected 1 0", req0_ready, req1_ready);
        end
        idle_inputs();
        cyc();
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        int order[$];
        int exp_o[3] = '{0, 0, 1};
        int c = 0;
        do_reset();
        req0_valid = 1; req0_lock = 1; req0_op = 4'h0; req0_a = 16'hFFFF; req0_b = 16'h0001;
        req1_valid = 1; req1_op = 4'h0; req1_a = 16'h0007; req1_b = 16'h0008;
        rsp0_ready = 1; rsp1_ready = 1;
        #1;
        while (order.size() < 3 && c < 30) begin
            if (req0_ready) order.push_back(0);
            else if (req1_ready) order.push_back(1);
            cyc();
            c++;
            if (order.size() == 1) begin
                req0_lock = 0;
                req0_op = 4'h1;
            end
            #1;
        end
        checks++;
        if (order.size() != 3) begin
            errors++;
            $display("FAIL lock_count: got %0d grants, expected 3", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != exp_o[i]) begin
                errors++;
                $display("FAIL lock_order%0d: got requester %0d, expected %0d", i, order[i], exp_o[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int last, g, age, win;
        bit pend;
        logic [FW+W-1:0] exp;
        logic xerr;
        logic [3:0] xop;
        logic [W-1:0] gr;
        logic [FW-1:0] gf;
        logic ge;
        do_reset();
        last = 1; pend = 0; age = 0; g = 0;
        exp = '0; xerr = 0; xop = 0;
        for (int c = 0; c < 400; c++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_op = 4'($urandom_range(0, 15));
            req1_op = 4'($urandom_range(0, 15));
            req0_a = 16'($urandom); req0_b = 16'($urandom);
            req1_a = 16'($urandom); req1_b = 16'($urandom);
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            win = -1;
            if (!pend) begin
                if (req0_valid && req1_valid) win = 1 - last;
                else if (req0_valid) win = 0;
                else if (req1_valid) win = 1;
            end
            checks++;
            if ({req0_ready, req1_ready, busy} !== {win == 0, win == 1, pend}) begin
                errors++;
                $display("FAIL rand_ctl c%0d: got rdy=%b%b busy=%b, expected %b%b %b",
                         c, req0_ready, req1_ready, busy, win == 0, win == 1, pend);
            end
            checks++;
            if ({rsp0_valid, rsp1_valid} !== {pend && age >= 2 && g == 0, pend && age >= 2 && g == 1}) begin
                errors++;
                $display("FAIL rand_vld c%0d: got %b%b, expected %b%b", c, rsp0_valid, rsp1_valid,
                         pend && age >= 2 && g == 0, pend && age >= 2 && g == 1);
            end
            if (pend && age == 1) begin
                checks++;
                if (alu_op !== (xerr ? 4'h0 : xop)) begin
                    errors++;
                    $display("FAIL rand_aluop c%0d: got %h, expected %h", c, alu_op, xerr ? 4'h0 : xop);
                end
            end
            if (pend && age >= 2) begin
                gr = g ? rsp1_result : rsp0_result;
                gf = g ? rsp1_flags : rsp0_flags;
                ge = g ? rsp1_err : rsp0_err;
                checks++;
                if ({ge, gf, gr} !== {xerr, exp}) begin
                    errors++;
                    $display("FAIL rand_rsp c%0d: got err=%b flg=%h res=%h, expected %b %h %h",
                             c, ge, gf, gr, xerr, exp[FW+W-1:W], exp[W-1:0]);
                end
                checks++;
                if ((g ? {rsp0_err, rsp0_flags, rsp0_result} : {rsp1_err, rsp1_flags, rsp1_result}) !== '0) begin
                    errors++;
                    $display("FAIL rand_other c%0d: got nonzero rsp on requester %0d, expected 0", c, 1 - g);
                end
            end
            if (win >= 0) begin
                g = win; pend = 1; age = 1;
                xop = win ? req1_op : req0_op;
                xerr = (xop >= 4'hD);
                exp = xerr ? '0 : ref_alu(xop, win ? req1_a : req0_a, win ? req1_b : req0_b);
            end else if (pend) begin
                if (age >= 2 && (g ? rsp1_ready : rsp0_ready)) begin
                    pend = 0;
                    last = g;
                end else begin
                    age++;
                end
            end
            cyc();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_reserved();
        test_rst_exec();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
